// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Bit-counter width for a WIDTH-bit frame (counter spans 0..WIDTH-1).
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle between an upstream producer, the serializer and the serial link.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] par_data;
    logic             par_valid;
    logic             par_ready;
    logic             bit_en;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    modport master (
        output par_data, par_valid, bit_en,
        input  par_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );

    modport slave (
        input  par_data, par_valid, bit_en,
        output par_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a word on valid/ready and shifts it out
// one bit per bit_en strobe, with zero-gap back-to-back frames.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              arst,
    piso_serializer_if.slave  bus
);

    localparam int unsigned   CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_width_check
        $error("piso_serializer: WIDTH must be >= 2");
    end

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shreg_adv_c;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             shifting_c;
    logic             last_c;
    logic             accept_c;

    assign shifting_c = (state_q == SHIFT);
    assign last_c     = shifting_c && (cnt_q == CNT_LAST);

    // Ready re-opens in the cycle the final bit is consumed so frames can abut.
    assign bus.par_ready = (state_q == IDLE) || (last_c && bus.bit_en);
    assign accept_c      = bus.par_valid && bus.par_ready;

    assign shreg_adv_c = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    shreg_d = bus.par_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.bit_en) begin
                    if (cnt_q == CNT_LAST) begin
                        // Clearing the register keeps ser_out at 0 while idle.
                        shreg_d = accept_c ? bus.par_data : '0;
                        cnt_d   = '0;
                        state_d = accept_c ? SHIFT : IDLE;
                    end else begin
                        shreg_d = shreg_adv_c;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ser_out   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign bus.ser_valid = shifting_c;
    assign bus.busy      = shifting_c;
    assign bus.ser_first = shifting_c && (cnt_q == '0);
    assign bus.ser_last  = last_c;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances side by side.
module tb_piso_serializer;

    logic clk;
    logic arst;
    int   n_cmp;
    int   n_err;

    piso_serializer_if #(.WIDTH(8)) if_m ();
    piso_serializer_if #(.WIDTH(8)) if_l ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk  (clk),
        .arst (arst),
        .bus  (if_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk  (clk),
        .arst (arst),
        .bus  (if_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] seq_m;
        logic [7:0] seq_l;
        n_cmp = 0;
        n_err = 0;

        arst           = 1'b1;
        if_m.par_data  = '0;
        if_m.par_valid = 1'b0;
        if_m.bit_en    = 1'b0;
        if_l.par_data  = '0;
        if_l.par_valid = 1'b0;
        if_l.bit_en    = 1'b0;

        // Reset state
        #1;
        chk("rst_valid_m", 8'(if_m.ser_valid), 8'h0);
        chk("rst_out_m",   8'(if_m.ser_out),   8'h0);
        chk("rst_busy_m",  8'(if_m.busy),      8'h0);
        chk("rst_valid_l", 8'(if_l.ser_valid), 8'h0);
        tick();
        tick();
        arst = 1'b0;
        #1;
        chk("rst_ready_m", 8'(if_m.par_ready), 8'h1);
        chk("rst_ready_l", 8'(if_l.par_ready), 8'h1);

        // 8'h0F on both instances, bit_en held high
        tick();
        if_m.par_data = 8'h0F; if_m.par_valid = 1'b1; if_m.bit_en = 1'b1;
        if_l.par_data = 8'h0F; if_l.par_valid = 1'b1; if_l.bit_en = 1'b1;
        #1;
        chk("0f_accept_ready", 8'(if_m.par_ready), 8'h1);
        tick();
        if_m.par_valid = 1'b0;
        if_l.par_valid = 1'b0;
        seq_m = 8'b0000_1111;
        seq_l = 8'b1111_0000;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("0f_m_out[%0d]", i),   8'(if_m.ser_out),   8'(seq_m[7-i]));
            chk($sformatf("0f_l_out[%0d]", i),   8'(if_l.ser_out),   8'(seq_l[7-i]));
            chk($sformatf("0f_m_valid[%0d]", i), 8'(if_m.ser_valid), 8'h1);
            chk($sformatf("0f_m_first[%0d]", i), 8'(if_m.ser_first), 8'(i == 0));
            chk($sformatf("0f_m_last[%0d]", i),  8'(if_m.ser_last),  8'(i == 7));
            chk($sformatf("0f_m_busy[%0d]", i),  8'(if_m.busy),      8'h1);
            tick();
        end
        #1;
        chk("0f_m_valid_end", 8'(if_m.ser_valid), 8'h0);
        chk("0f_l_valid_end", 8'(if_l.ser_valid), 8'h0);
        chk("0f_m_busy_end",  8'(if_m.busy),      8'h0);
        if_l.bit_en = 1'b0;

        // Back-to-back 8'hFF then 8'h00, par_valid held through the first frame
        tick();
        if_m.par_data = 8'hFF; if_m.par_valid = 1'b1; if_m.bit_en = 1'b1;
        tick();
        if_m.par_data = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) if_m.par_valid = 1'b0;
            #1;
            chk($sformatf("b2b_out[%0d]", i),   8'(if_m.ser_out),   (i < 8) ? 8'h1 : 8'h0);
            chk($sformatf("b2b_valid[%0d]", i), 8'(if_m.ser_valid), 8'h1);
            chk($sformatf("b2b_first[%0d]", i), 8'(if_m.ser_first), 8'((i == 0) || (i == 8)));
            chk($sformatf("b2b_last[%0d]", i),  8'(if_m.ser_last),  8'((i == 7) || (i == 15)));
            chk($sformatf("b2b_ready[%0d]", i), 8'(if_m.par_ready), 8'((i == 7) || (i == 15)));
            tick();
        end
        #1;
        chk("b2b_valid_end", 8'(if_m.ser_valid), 8'h0);

        // Stall: bit_en every third cycle, word 8'hA5
        tick();
        if_m.par_data = 8'hA5; if_m.par_valid = 1'b1; if_m.bit_en = 1'b0;
        #1;
        chk("stall_accept_ready", 8'(if_m.par_ready), 8'h1);
        tick();
        if_m.par_valid = 1'b0;
        seq_m = 8'b1010_0101;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 3; k++) begin
                if_m.bit_en = (k == 2);
                #1;
                chk($sformatf("stall_out[%0d.%0d]", b, k),   8'(if_m.ser_out),   8'(seq_m[7-b]));
                chk($sformatf("stall_cnt[%0d.%0d]", b, k),   8'(u_msb.cnt_q),    8'(b));
                chk($sformatf("stall_first[%0d.%0d]", b, k), 8'(if_m.ser_first), 8'(b == 0));
                chk($sformatf("stall_last[%0d.%0d]", b, k),  8'(if_m.ser_last),  8'(b == 7));
                chk($sformatf("stall_ready[%0d.%0d]", b, k), 8'(if_m.par_ready), 8'((b == 7) && (k == 2)));
                tick();
            end
        end
        #1;
        chk("stall_valid_end", 8'(if_m.ser_valid), 8'h0);

        // Busy protection: par_valid held, par_data scrambled while 8'h3C is in flight
        tick();
        if_m.par_data = 8'h3C; if_m.par_valid = 1'b1; if_m.bit_en = 1'b1;
        tick();
        seq_m = 8'b0011_1100;
        for (int i = 0; i < 8; i++) begin
            if_m.par_data = 8'($urandom);
            if (i == 7) if_m.par_valid = 1'b0;
            #1;
            chk($sformatf("busy_out[%0d]", i),   8'(if_m.ser_out),   8'(seq_m[7-i]));
            chk($sformatf("busy_ready[%0d]", i), 8'(if_m.par_ready), 8'(i == 7));
            tick();
        end
        #1;
        chk("busy_valid_end", 8'(if_m.ser_valid), 8'h0);

        // Reset mid-frame after three bits, then a clean 8'h80 frame
        tick();
        if_m.par_data = 8'hC3; if_m.par_valid = 1'b1; if_m.bit_en = 1'b1;
        tick();
        if_m.par_valid = 1'b0;
        tick();
        tick();
        tick();
        #2;
        chk("mid_pre_valid", 8'(if_m.ser_valid), 8'h1);
        arst = 1'b1;
        #1;
        chk("mid_rst_valid", 8'(if_m.ser_valid), 8'h0);
        chk("mid_rst_out",   8'(if_m.ser_out),   8'h0);
        chk("mid_rst_busy",  8'(if_m.busy),      8'h0);
        chk("mid_rst_first", 8'(if_m.ser_first), 8'h0);
        tick();
        arst = 1'b0;
        #1;
        chk("mid_rel_ready", 8'(if_m.par_ready), 8'h1);
        if_m.par_data = 8'h80; if_m.par_valid = 1'b1;
        tick();
        if_m.par_valid = 1'b0;
        seq_m = 8'b1000_0000;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("post_out[%0d]", i),   8'(if_m.ser_out),   8'(seq_m[7-i]));
            chk($sformatf("post_first[%0d]", i), 8'(if_m.ser_first), 8'(i == 0));
            chk($sformatf("post_last[%0d]", i),  8'(if_m.ser_last),  8'(i == 7));
            tick();
        end
        #1;
        chk("post_valid_end", 8'(if_m.ser_valid), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled cycle. A downstream-supplied bit_en strobe sets the bit rate. It is the transmit-side counterpart of the team's serial-in shift register and feeds that receiver or any 1-bit serial link.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 transmitted first.

Ports:
clk  input  1  clock; all state updates on the rising edge.
arst  input  1  reset, asynchronous, active-high.
par_data  input  WIDTH  word to transmit; sampled only on an accepted handshake.
par_valid  input  1  par_data is valid.
par_ready  output  1  block can accept a word this cycle (combinational).
bit_en  input  1  advance strobe; the current serial bit is consumed in any SHIFT cycle where it is 1.
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out carries a live data bit.
ser_first  output  1  current bit is bit 0 of the frame.
ser_last  output  1  current bit is bit WIDTH-1 of the frame.
busy  output  1  equals state == SHIFT.

Behaviour:
- Reset (arst=1, takes effect immediately):
  - State IDLE.
  - Shift register, bit counter, ser_out, ser_valid, ser_first and ser_last all 0.
  - A frame in progress is abandoned with no partial completion.
  - After release, par_ready=1.
- State machine:
  - Two states: IDLE and SHIFT.
  - Bit counter cnt is $clog2(WIDTH) bits wide, range 0..WIDTH-1.
- IDLE:
  - par_ready=1 and ser_valid=0; bit_en is ignored.
  - On par_valid && par_ready at edge T: load the shift register with par_data, set cnt=0, go to SHIFT.
  - The first bit appears on ser_out in cycle T+1 (1-cycle latency) with ser_valid=1 and ser_first=1.
- SHIFT:
  - ser_valid=1 throughout.
  - ser_out = shreg[WIDTH-1] when MSB_FIRST=1, otherwise shreg[0].
  - ser_first = (cnt==0); ser_last = (cnt==WIDTH-1).
- bit_en=0 in SHIFT: every register holds. ser_out, the flags and cnt remain stable for any number of cycles.
- bit_en=1 in SHIFT with cnt < WIDTH-1:
  - Shift the register toward the output end (left for MSB_FIRST, right otherwise), filling with 0.
  - cnt increments.
- bit_en=1 in SHIFT with cnt == WIDTH-1 (last bit consumed):
  - par_ready = 1 in that cycle (par_ready = IDLE || (SHIFT && ser_last && bit_en)).
  - If par_valid=1, the new word is loaded, cnt=0 and the state stays SHIFT. The next frame's first bit follows with zero gap (back-to-back).
  - If par_valid=0, go to IDLE; ser_valid=0 next cycle.
- par_valid while par_ready=0 has no effect. par_data may change freely while busy without corrupting the frame.
- Output integrity: ser_out, ser_first, ser_last and busy are driven from registers (shreg/cnt/state) only. par_ready is the only combinational output; it depends on bit_en.
- A frame on the wire is exactly WIDTH consumed bits. No start/stop bits are inserted.

Decomposition:
- Shared package piso_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t;
  - localparam function cnt_w(WIDTH) = $clog2(WIDTH).
- No sub-module required. Optional leaf bit_counter (terminal-count flag, hold/clear/increment) if reused by the matching receiver.
- Elaboration check: $error if WIDTH < 2.

Test Plan:
- Reset: assert arst mid-cycle with no clock edge -> ser_valid=0, ser_out=0, busy=0 immediately; after release par_ready=1.
- MSB_FIRST=1, WIDTH=8, par_data=8'h0F accepted at T, bit_en=1 constantly:
  - ser_out for T+1..T+8 = 0,0,0,0,1,1,1,1.
  - ser_first only at T+1, ser_last only at T+8.
  - ser_valid=0 at T+9.
- MSB_FIRST=0 instance, par_data=8'h0F -> ser_out = 1,1,1,1,0,0,0,0 over 8 cycles.
- Back-to-back: 8'hFF then 8'h00 with par_valid held -> 16 contiguous ser_valid cycles (8 ones, then 8 zeros); second acceptance coincides with ser_last && bit_en; ser_first asserts at cycle 9.
- Stall: bit_en high every 3rd cycle, word 8'hA5 -> each bit held 3 cycles; sequence 1,0,1,0,0,1,0,1; cnt never skips.
- Busy protection and reset mid-frame:
  - With par_valid=1 and data toggling during the frame, par_ready=0 except the last-bit cycle, and the output matches the originally accepted word.
  - Assert arst after 3 bits -> ser_valid drops immediately; the next accepted word 8'h80 transmits cleanly from ser_first.
